eeprom_access_arbiter: RTL and testbench
========================================

Name: eeprom_access_arbiter

Overview:
- Shares one I2C byte-access controller (single-byte EEPROM write/read engine driving scl/sda to the 24LC64) between two requesters: a write port (key_wr path) and a read port (key_rd/display path).
- Arbitrates round-robin, latches the winner's address/data, issues a one-cycle start to the I2C engine and waits for its end pulse.
- Enforces the EEPROM internal write-cycle recovery time before acknowledging a write, then returns read data or a write ack to the requester.

Parameters:
- ADDR_W, 16, EEPROM byte-address width (24LC64 uses 16-bit two-byte address).
- DATA_W, 8, data byte width.
- WR_WAIT_CYC, 250000, sys_clk cycles of post-write recovery (5 ms at 50 MHz); must be >= 1.
- TIMEOUT_CYC, 1000000, watchdog limit in cycles for the I2C end pulse (used only with ARB_TIMEOUT_EN).

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- wr_req  in  1  write request, level; held until wr_ack.
- wr_addr  in  ADDR_W  write byte address; valid while wr_req=1.
- wr_data  in  DATA_W  write byte; valid while wr_req=1.
- wr_ack  out  1  one-cycle pulse: write complete, recovery elapsed.
- rd_req  in  1  read request, level; held until rd_ack.
- rd_addr  in  ADDR_W  read byte address; valid while rd_req=1.
- rd_ack  out  1  one-cycle pulse: rd_data valid.
- rd_data  out  DATA_W  last read byte; holds until next read completes.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on watchdog abort (constant 0 without ARB_TIMEOUT_EN).
- i2c_start  out  1  one-cycle start pulse to I2C engine.
- i2c_wr_en  out  1  write-op select, level, held ISSUE..WAIT_END.
- i2c_rd_en  out  1  read-op select, level, held ISSUE..WAIT_END.
- i2c_byte_addr  out  ADDR_W  latched address to engine.
- i2c_wr_data  out  DATA_W  latched write byte to engine.
- i2c_end  in  1  one-cycle pulse from engine: operation finished.
- i2c_rd_data  in  DATA_W  byte read by engine; valid in the i2c_end cycle.

Behaviour:
- Reset: state IDLE; all outputs 0; rd_data=0; last_served=READ (so write wins the first tie); counters 0.
- States: IDLE, ISSUE, WAIT_END, WR_RECOVER, DONE.
- IDLE: if exactly one request is asserted, grant it. If both are asserted, grant the side opposite last_served. On grant, register addr/data into i2c_byte_addr/i2c_wr_data, set i2c_wr_en or i2c_rd_en, update last_served, go to ISSUE. No request: stay in IDLE.
- ISSUE: i2c_start=1 for exactly this cycle. Next state WAIT_END.
- WAIT_END: wait for i2c_end.
  - Read: capture rd_data<=i2c_rd_data, go to DONE.
  - Write: go to WR_RECOVER, counter cleared.
  - Clear i2c_wr_en/i2c_rd_en on that edge.
- WR_RECOVER: counter increments each cycle; when it reaches WR_WAIT_CYC-1, go to DONE. Total recovery is exactly WR_WAIT_CYC cycles.
- DONE: pulse wr_ack or rd_ack for one cycle, then IDLE.
  - Requester must drop its req on the edge ending the ack cycle, so it is low when IDLE re-samples.
  - Minimum spacing between back-to-back grants is 1 IDLE cycle.
- Latency, read: grant edge to i2c_start = 1 cycle; i2c_end to rd_ack = 1 cycle.
- Latency, write: i2c_end to wr_ack = WR_WAIT_CYC+1 cycles.
- Requests arriving while busy are held by the requester and are not lost; there is no preemption.
- i2c_end outside WAIT_END is ignored.
- Address/data changes on the ports after grant do not affect the op in flight.
- Reset mid-operation: immediate return to reset values; no ack is issued; the in-flight op is abandoned (the engine is reset by the same sys_rst).

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: WAIT_END counts cycles. If TIMEOUT_CYC cycles elapse without i2c_end, the block clears i2c_wr_en/i2c_rd_en, pulses err for one cycle, and pulses the pending requester's ack (rd_data unchanged) so the requester is released, then returns to IDLE.
- Not defined: WAIT_END waits indefinitely; err is tied 0; no watchdog counter is synthesized.

Test Plan (WR_WAIT_CYC=8, TIMEOUT_CYC=50):
- Write only: wr_req, wr_addr=16'h0003, wr_data=8'hA5 -> next cycle i2c_wr_en=1 and i2c_byte_addr=0003, i2c_wr_data=A5; i2c_start one pulse; after i2c_end, wr_ack exactly 9 cycles later; busy low the cycle after.
- Read only: rd_req, rd_addr=16'h0003; model returns i2c_rd_data=8'hA5 with i2c_end -> rd_ack 1 cycle later, rd_data=A5 held afterwards.
- Tie: wr_req and rd_req asserted in the same cycle from reset -> write served first, read served next; repeat the tie -> read served first (round-robin).
- Stimulus change: alter wr_data to 8'h00 during WAIT_END -> i2c_wr_data stays A5; stray i2c_end while IDLE -> no ack, state unchanged.
- Reset mid-op: assert sys_rst during WR_RECOVER -> all outputs 0 asynchronously, no wr_ack; after release, a new read grants normally.
- ARB_TIMEOUT_EN: withhold i2c_end -> after 50 cycles in WAIT_END, err and rd_ack pulse together, rd_data unchanged, state IDLE; without the macro, the block stays busy.

Source files
------------

// File: rtl/eeprom_access_arbiter_if.sv
// Request/ack and I2C-engine signal bundle for eeprom_access_arbiter.
// slave = arbiter side, master = requesters plus I2C engine side.
interface eeprom_access_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              err;
    logic              i2c_start;
    logic              i2c_wr_en;
    logic              i2c_rd_en;
    logic [ADDR_W-1:0] i2c_byte_addr;
    logic [DATA_W-1:0] i2c_wr_data;
    logic              i2c_end;
    logic [DATA_W-1:0] i2c_rd_data;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, i2c_end, i2c_rd_data,
        output wr_ack, rd_ack, rd_data, busy, err,
               i2c_start, i2c_wr_en, i2c_rd_en, i2c_byte_addr, i2c_wr_data
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, i2c_end, i2c_rd_data,
        input  wr_ack, rd_ack, rd_data, busy, err,
               i2c_start, i2c_wr_en, i2c_rd_en, i2c_byte_addr, i2c_wr_data
    );
endinterface

// File: rtl/eeprom_access_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C EEPROM engine between a write and a read port.
// Optional macro ARB_TIMEOUT_EN adds a watchdog on the engine end pulse (TIMEOUT_CYC cycles).
module eeprom_access_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WR_WAIT_CYC = 250000
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1000000
`endif
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    eeprom_access_arbiter_if.slave arb_if
);
    localparam int REC_W = (WR_WAIT_CYC > 1) ? $clog2(WR_WAIT_CYC) : 1;
    localparam logic [REC_W-1:0] REC_LAST = REC_W'(WR_WAIT_CYC - 1);
    localparam logic [REC_W-1:0] REC_ONE  = REC_W'(1);
`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
`endif

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_END, WR_RECOVER, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [REC_W-1:0]  rec_q, rec_d;
`ifdef ARB_TIMEOUT_EN
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              tout_q, tout_d;
`endif
    logic              grant_wr;

    // Write wins when alone, or on a tie when the read side was served last.
    assign grant_wr = arb_if.wr_req && (!arb_if.rd_req || !last_wr_q);

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_en_d   = wr_en_q;
        rd_en_d   = rd_en_q;
        rdata_d   = rdata_q;
        rec_d     = rec_q;
`ifdef ARB_TIMEOUT_EN
        wd_d      = wd_q;
        tout_d    = tout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (arb_if.wr_req || arb_if.rd_req) begin
                    op_wr_d   = grant_wr;
                    last_wr_d = grant_wr;
                    addr_d    = grant_wr ? arb_if.wr_addr : arb_if.rd_addr;
                    if (grant_wr) begin
                        wdata_d = arb_if.wr_data;
                    end
                    wr_en_d   = grant_wr;
                    rd_en_d   = !grant_wr;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_END;
`ifdef ARB_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            WAIT_END: begin
                if (arb_if.i2c_end) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    rec_d   = '0;
                    if (op_wr_q) begin
                        state_d = WR_RECOVER;
                    end else begin
                        rdata_d = arb_if.i2c_rd_data;
                        state_d = DONE;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    // Abort: release the requester with an ack, rd_data untouched.
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    tout_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
`endif
            end
            WR_RECOVER: begin
                if (rec_q == REC_LAST) begin
                    state_d = DONE;
                end else begin
                    rec_d = rec_q + REC_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
                tout_d  = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rdata_q   <= '0;
            rec_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            wd_q      <= '0;
            tout_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            rdata_q   <= rdata_d;
            rec_q     <= rec_d;
`ifdef ARB_TIMEOUT_EN
            wd_q      <= wd_d;
            tout_q    <= tout_d;
`endif
        end
    end

    assign arb_if.busy          = (state_q != IDLE);
    assign arb_if.i2c_start     = (state_q == ISSUE);
    assign arb_if.wr_ack        = (state_q == DONE) && op_wr_q;
    assign arb_if.rd_ack        = (state_q == DONE) && !op_wr_q;
    assign arb_if.rd_data       = rdata_q;
    assign arb_if.i2c_wr_en     = wr_en_q;
    assign arb_if.i2c_rd_en     = rd_en_q;
    assign arb_if.i2c_byte_addr = addr_q;
    assign arb_if.i2c_wr_data   = wdata_q;
`ifdef ARB_TIMEOUT_EN
    assign arb_if.err           = (state_q == DONE) && tout_q;
`else
    assign arb_if.err           = 1'b0;
`endif
endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Bench for eeprom_access_arbiter: directed scenarios plus random traffic against a
// timestamp-based model of the arbitration and handshake timing.
module tb_eeprom_access_arbiter;
    localparam int AW = 16, DW = 8, WAIT = 8, TOUT = 50;

    logic sys_clk = 1'b0;
    logic sys_rst;

    eeprom_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    eeprom_access_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WR_WAIT_CYC(WAIT)
`ifdef ARB_TIMEOUT_EN
        , .TIMEOUT_CYC(TOUT)
`endif
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .arb_if (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(negedge sys_clk);
        #1;
    endtask

    function automatic logic sig(input int id);
        case (id)
            0:       return bus.wr_ack;
            1:       return bus.rd_ack;
            2:       return bus.i2c_end;
            default: return bus.err;
        endcase
    endfunction

    task automatic wait_sig(input int id, input int budget, input string name, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (sig(id)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_chk++;
            $display("FAIL %s: no pulse within %0d cycles", name, budget);
        end
    endtask

    // ---------------- I2C engine stand-in ----------------
    bit eng_act = 0, eng_withhold = 0, eng_fix_en = 1, stray_pulse = 0;
    int eng_cnt = 0, eng_dmin = 3, eng_dmax = 3;
    logic [DW-1:0] eng_fix_val = 8'hA5;

    initial begin
        bus.i2c_end = 1'b0;
        bus.i2c_rd_data = '0;
        forever begin
            @(negedge sys_clk);
            bus.i2c_end = 1'b0;
            bus.i2c_rd_data = DW'($urandom);
            if (sys_rst) begin
                eng_act = 0;
            end else if (eng_act) begin
                if (eng_cnt <= 1) begin
                    eng_act = 0;
                    bus.i2c_end = 1'b1;
                    bus.i2c_rd_data = eng_fix_en ? eng_fix_val : DW'($urandom);
                end else begin
                    eng_cnt--;
                end
            end else if (bus.i2c_start && !eng_withhold) begin
                eng_act = 1;
                eng_cnt = $urandom_range(eng_dmax, eng_dmin);
            end else if (stray_pulse && !bus.busy) begin
                bus.i2c_end = 1'b1;
                stray_pulse = 0;
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    // An operation is described by its grant cycle g, end cycle e and ack cycle;
    // every output of cycle n follows from where n falls relative to those.
    bit m_act, m_op_wr, m_e_known, m_tout, m_last_wr;
    int m_g, m_e, m_ack;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    initial begin
        int k, n;
        bit e_en;
        forever begin
            @(posedge sys_clk);
            k = cyc;
            cyc++;
            n = cyc;
            if (sys_rst) begin
                m_act = 0; m_last_wr = 0; m_e_known = 0; m_tout = 0;
                m_addr = '0; m_wdata = '0; m_rdata = '0;
            end else begin
                if (!m_act) begin
                    if (bus.wr_req || bus.rd_req) begin
                        m_op_wr   = bus.wr_req && (!bus.rd_req || !m_last_wr);
                        m_last_wr = m_op_wr;
                        m_act = 1; m_g = k; m_e_known = 0; m_tout = 0;
                        m_addr = m_op_wr ? bus.wr_addr : bus.rd_addr;
                        if (m_op_wr) m_wdata = bus.wr_data;
                    end
                end else if (!m_e_known) begin
                    if (k >= m_g + 2 && bus.i2c_end) begin
                        m_e = k; m_e_known = 1;
                        m_ack = m_op_wr ? k + WAIT + 1 : k + 1;
                        if (!m_op_wr) m_rdata = bus.i2c_rd_data;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (k == m_g + TOUT + 1) begin
                        m_e = k; m_e_known = 1; m_tout = 1; m_ack = k + 1;
                    end
`endif
                end else if (k == m_ack) begin
                    m_act = 0;
                end
                #1;
                if (chk_en && !sys_rst) begin
                    e_en = m_act && (!m_e_known || n <= m_e);
                    check("busy", bus.busy, m_act);
                    check("i2c_start", bus.i2c_start, m_act && n == m_g + 1);
                    check("i2c_wr_en", bus.i2c_wr_en, e_en && m_op_wr);
                    check("i2c_rd_en", bus.i2c_rd_en, e_en && !m_op_wr);
                    check("wr_ack", bus.wr_ack, m_act && m_e_known && n == m_ack && m_op_wr);
                    check("rd_ack", bus.rd_ack, m_act && m_e_known && n == m_ack && !m_op_wr);
                    check("err", bus.err, m_act && m_tout && n == m_ack);
                    check("rd_data", bus.rd_data, m_rdata);
                    check("i2c_byte_addr", bus.i2c_byte_addr, m_addr);
                    if (m_act && m_op_wr) check("i2c_wr_data", bus.i2c_wr_data, m_wdata);
                end
            end
        end
    end

    // ---------------- directed scenarios then random traffic ----------------
    initial begin
        int t_end, t_ack, t_start;
        bit acc;
        sys_rst = 1'b1;
        bus.wr_req = 0; bus.rd_req = 0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        repeat (3) step();
        check("reset_ctrl", {bus.busy, bus.err, bus.i2c_start, bus.i2c_wr_en,
                             bus.i2c_rd_en, bus.wr_ack, bus.rd_ack}, 0);
        check("reset_rd_data", bus.rd_data, 0);
        check("reset_addr", bus.i2c_byte_addr, 0);
        sys_rst = 1'b0;
        chk_en = 1;
        step();

        // Write only; port data changed mid-flight must not leak into the engine.
        bus.wr_req = 1; bus.wr_addr = 16'h0003; bus.wr_data = 8'hA5;
        step();
        check("wr_issue_en", bus.i2c_wr_en, 1);
        check("wr_issue_start", bus.i2c_start, 1);
        check("wr_issue_addr", bus.i2c_byte_addr, 16'h0003);
        bus.wr_data = 8'h00; bus.wr_addr = 16'hFFFF;
        step();
        check("wr_data_held", bus.i2c_wr_data, 8'hA5);
        wait_sig(2, 20, "wr_end", t_end);
        wait_sig(0, 20, "wr_ack", t_ack);
        check("wr_ack_latency", t_ack - t_end, WAIT + 1);
        bus.wr_req = 0;
        step();
        check("busy_after_wr", bus.busy, 0);

        // Read only.
        bus.rd_req = 1; bus.rd_addr = 16'h0003;
        step();
        check("rd_issue_en", bus.i2c_rd_en, 1);
        wait_sig(2, 20, "rd_end", t_end);
        wait_sig(1, 20, "rd_ack", t_ack);
        check("rd_ack_latency", t_ack - t_end, 1);
        check("rd_data_value", bus.rd_data, 8'hA5);
        bus.rd_req = 0;
        repeat (3) step();
        check("rd_data_hold", bus.rd_data, 8'hA5);

        // Stray engine end while idle.
        stray_pulse = 1;
        acc = 0;
        repeat (4) begin
            step();
            acc = acc | bus.wr_ack | bus.rd_ack | bus.busy;
        end
        check("stray_end_ignored", acc, 0);

        // Tie from reset: write first; re-tie while read pending: read first.
        sys_rst = 1; step(); step(); sys_rst = 0;
        bus.wr_req = 1; bus.wr_addr = 16'h0010; bus.wr_data = 8'h11;
        bus.rd_req = 1; bus.rd_addr = 16'h0020;
        step();
        check("tie1_write_first", {bus.i2c_wr_en, bus.i2c_rd_en}, 2'b10);
        wait_sig(0, 40, "tie1_wr_ack", t_ack);
        bus.wr_req = 0;
        step();
        bus.wr_req = 1; bus.wr_addr = 16'h0030; bus.wr_data = 8'h33;
        step();
        check("tie2_read_first", {bus.i2c_wr_en, bus.i2c_rd_en}, 2'b01);
        check("tie2_read_addr", bus.i2c_byte_addr, 16'h0020);
        wait_sig(1, 40, "tie2_rd_ack", t_ack);
        bus.rd_req = 0;
        step(); step();
        check("tie2_write_next", {bus.i2c_wr_en, bus.i2c_rd_en}, 2'b10);
        check("tie2_write_addr", bus.i2c_byte_addr, 16'h0030);
        wait_sig(0, 40, "tie2_wr_ack", t_ack);
        bus.wr_req = 0;
        step();

        // Reset during write recovery.
        bus.wr_req = 1; bus.wr_addr = 16'h0044; bus.wr_data = 8'h5A;
        wait_sig(2, 20, "rstmid_end", t_end);
        repeat (3) step();
        sys_rst = 1; bus.wr_req = 0;
        #1;
        check("rst_async_ctrl", {bus.busy, bus.err, bus.i2c_start, bus.i2c_wr_en,
                                 bus.i2c_rd_en, bus.wr_ack, bus.rd_ack}, 0);
        check("rst_async_data", {bus.i2c_byte_addr, bus.i2c_wr_data, bus.rd_data}, 0);
        step(); step();
        sys_rst = 0;
        acc = 0;
        repeat (12) begin
            step();
            acc = acc | bus.wr_ack;
        end
        check("rst_no_wr_ack", acc, 0);
        bus.rd_req = 1; bus.rd_addr = 16'h0040;
        step();
        check("post_rst_read_grant", bus.i2c_rd_en, 1);
        wait_sig(1, 20, "post_rst_rd_ack", t_ack);
        bus.rd_req = 0;
        step();

        // Engine never ends the operation.
        eng_withhold = 1;
        bus.rd_req = 1; bus.rd_addr = 16'h0050;
        step();
        t_start = cyc;
        check("tout_issue", bus.i2c_start, 1);
`ifdef ARB_TIMEOUT_EN
        wait_sig(1, TOUT + 30, "tout_rd_ack", t_ack);
        check("tout_latency", t_ack - t_start, TOUT + 1);
        check("tout_err_with_ack", bus.err, 1);
        check("tout_rd_data_kept", bus.rd_data, 8'hA5);
        bus.rd_req = 0;
        step();
        check("tout_idle", bus.busy, 0);
`else
        repeat (TOUT + 10) step();
        check("no_wd_busy", {bus.busy, bus.i2c_rd_en, bus.err}, 3'b110);
        sys_rst = 1; bus.rd_req = 0;
        step(); step();
        sys_rst = 0;
`endif
        eng_withhold = 0;
        step();

        // Random traffic.
        eng_fix_en = 0; eng_dmin = 1; eng_dmax = 8;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (bus.wr_req) begin
                if (bus.wr_ack) bus.wr_req = 0;
                else if ($urandom_range(3) == 0) begin
                    bus.wr_addr = AW'($urandom); bus.wr_data = DW'($urandom);
                end
            end else if ($urandom_range(5) == 0) begin
                bus.wr_req = 1; bus.wr_addr = AW'($urandom); bus.wr_data = DW'($urandom);
            end
            if (bus.rd_req) begin
                if (bus.rd_ack) bus.rd_req = 0;
                else if ($urandom_range(3) == 0) bus.rd_addr = AW'($urandom);
            end else if ($urandom_range(5) == 0) begin
                bus.rd_req = 1; bus.rd_addr = AW'($urandom);
            end
            if (!bus.busy && $urandom_range(15) == 0) stray_pulse = 1;
        end
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.wr_ack) bus.wr_req = 0;
            if (bus.rd_ack) bus.rd_req = 0;
        end
        check("final_idle", {bus.busy, bus.wr_req, bus.rd_req}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1);
    end
endmodule
